mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, byte-laned data/instruction memory between the core's instruction-fetch path and its load/store path. Grants one access at a time, drives the memory address/write-enable/byte lanes for a fixed parameterised latency, and returns read data with a one-cycle valid pulse. The core uses `if_stall`/`d_stall` to hold its PC and pipeline state. Sits between `mips_core` and the memory model inside the machine top.

## Interface
- `MEM_LATENCY`, 2: cycles the memory needs per access; legal range 1..15.
- `ADDR_W`, 32: address width.

- `clk` input 1: single clock, rising edge.
- `rst_b` input 1: synchronous, active-high reset (asserted = 1, sampled on `clk`).
- `halted` input 1: core halted; no new grants while high.
- `if_req` input 1: fetch request, level, held until `if_valid`.
- `if_addr` input ADDR_W: fetch address.
- `if_valid` output 1: one-cycle pulse, `if_rdata` valid.
- `if_rdata` output 32: fetched word, lane 0 in bits [31:24].
- `if_stall` output 1: `if_req` high and `if_valid` low.
- `d_req` input 1: data request, level, held until `d_valid`.
- `d_we` input 1: 1 = store, 0 = load; stable while `d_req` is high.
- `d_addr` input ADDR_W: data address.
- `d_wdata` input 4x8 (`[7:0] [0:3]`): store bytes.
- `d_valid` output 1: one-cycle pulse; load data valid or store done.
- `d_rdata` output 4x8: load bytes.
- `d_stall` output 1: `d_req` high and `d_valid` low.
- `mem_addr` output ADDR_W: word address to memory; bits [1:0] forced to 0.
- `mem_write_en` output 1: memory write strobe.
- `mem_data_in` output 4x8: bytes written to memory.
- `mem_data_out` input 4x8: bytes read from memory.
- `busy` output 1: state is not IDLE.

## Operation
- FSM states:
  - IDLE: samples requests.
  - ACCESS: counts `MEM_LATENCY` cycles.
  - RESP: pulses valid for one cycle, then returns to IDLE.
- Arbitration in IDLE:
  - Only one request present and `halted` = 0: grant it.
  - Both present: round-robin; grant the side not granted last.
  - `last_gnt` resets to DATA, so the first tie goes to fetch.
- On grant:
  - Latch address (bits [1:0] cleared), the `we` flag and `d_wdata`.
  - Load the counter with `MEM_LATENCY-1`, enter ACCESS.
- ACCESS:
  - `mem_addr` and `mem_data_in` are driven from the latched values every cycle.
  - `mem_write_en` = 1 only in the first ACCESS cycle, and only for stores.
  - The counter decrements each cycle. At count 0, latch `mem_data_out` into the granted side's rdata register (loads and fetches only) and enter RESP.
- RESP: the granted side's valid = 1 for exactly one cycle, then IDLE.
- Requesters must drop `req` by the edge after their valid pulse; a req still high in IDLE starts a new access.
- Stores leave `d_rdata` unchanged.
- IDLE outputs: `mem_addr` = 0, `mem_data_in` = 0, `mem_write_en` = 0.
- `halted`:
  - Blocks grants only in IDLE.
  - An in-flight access always completes, including its RESP.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values:
  - state IDLE, counter 0, `last_gnt` = DATA.
  - `if_valid`, `d_valid`, `mem_write_en`, `busy` all 0.
  - `mem_addr`, `mem_data_in`, `if_rdata`, `d_rdata` all 0.
- Latency, with req first seen high in IDLE at edge 0:
  - ACCESS occupies cycles 1..`MEM_LATENCY`.
  - Valid is high in cycle `MEM_LATENCY`+1.
  - Next grant is possible at the edge ending cycle `MEM_LATENCY`+2.
  - Throughput is one access per `MEM_LATENCY`+2 cycles.
- Read data: `mem_data_out` is sampled at the edge ending the last ACCESS cycle and held in rdata until the next access of that side.
- `if_stall`/`d_stall` are combinational from req and valid; all other outputs are registered.
- Reset mid-access:
  - Abort to IDLE immediately.
  - No valid pulse; `mem_write_en` drops in the same cycle.
  - A store already strobed is not undone.
- Simultaneous `rst_b` and requests: reset wins; the requests are sampled again after reset releases.
- `MEM_LATENCY` = 1: ACCESS lasts one cycle, and the write strobe and read sampling fall in that same cycle.

## Structure
- Shared package `mips_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t`
  - `typedef logic [7:0] byte_lanes_t [0:3]`
  - `typedef enum logic {GNT_IF, GNT_D} gnt_t`
  - constant `WORD_BYTES = 4`
- One sub-module, `arb2_rr`:
  - Two-requester round-robin picker with `last_gnt` state.
  - Updates only on an enable pulse asserted at grant.
- Counter, FSM and datapath latches live in `mem_port_arbiter`; counter width is `$clog2(MEM_LATENCY+1)`.

## Test plan
- **Fetch only:** `MEM_LATENCY`=2, fetch of 0x0000_0040, memory returns `{8'h20,8'h08,8'h00,8'h05}`. Expect `if_valid` in cycle 3, `if_rdata` = 0x2008_0005, `mem_write_en` never 1.
- **Store then load:** store `d_wdata` `{DE,AD,BE,EF}` to 0x0000_0103, then load from the same address. Expect `mem_addr` = 0x0000_0100 in both accesses, `mem_write_en` high for exactly one cycle, `d_rdata` = 0xDEADBEEF.
- **Tie after reset:** `if_req` and `d_req` rise together after reset. Expect fetch granted first, data second, fetch again on the next tie.
- **Halted:** raise `halted` during an ACCESS with `d_req` pending. Expect the current access's valid pulse, then `busy` = 0 and no new `mem_addr` for at least 10 cycles.
- **Reset mid-access:** assert `rst_b` in the second ACCESS cycle of a load. Expect no `d_valid`, all outputs at reset values on the next cycle, and a clean grant after release.
- **Latency 1:** `MEM_LATENCY`=1, back-to-back fetches. Expect a valid every 3 cycles and `if_stall` high in exactly 2 of every 3 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the core's memory-side blocks: arbiter states, byte-laned
// words and grant identifiers.
package mips_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;

   typedef logic [7:0] byte_lanes_t [0:3];

   typedef enum logic {GNT_IF, GNT_D} gnt_t;

   localparam int WORD_BYTES = 4;

   // Lane 0 is the most significant byte of the packed word.
   function automatic logic [31:0] pack_lanes(input byte_lanes_t lanes);
      return {lanes[0], lanes[1], lanes[2], lanes[3]};
   endfunction

endpackage

// File: rtl/arb2_rr.sv
// Two-requester round-robin picker; the remembered winner advances only when
// the caller actually grants.
module arb2_rr
   import mips_pkg::*;
(
   input  logic clk,
   input  logic rst_b,
   input  logic req_if,
   input  logic req_d,
   input  logic en,
   output logic gnt_d
);

   gnt_t last_gnt_reg;
   gnt_t pick;

   always_comb begin
      pick = GNT_IF;
      if (req_if && req_d) begin
         pick = (last_gnt_reg == GNT_D) ? GNT_IF : GNT_D;
      end else if (req_d) begin
         pick = GNT_D;
      end
   end

   assign gnt_d = (pick == GNT_D);

   // Starting at DATA makes the first tie go to fetch.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         last_gnt_reg <= GNT_D;
      end else if (en) begin
         last_gnt_reg <= pick;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported byte-laned memory between instruction fetch and
// load/store, one access at a time, with a fixed access latency.
module mem_port_arbiter
   import mips_pkg::*;
#(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = 32
)
(
   input  logic              clk,
   input  logic              rst_b,
   input  logic              halted,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [31:0]       if_rdata,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [7:0]        d_wdata [0:3],
   output logic              d_valid,
   output logic [7:0]        d_rdata [0:3],
   output logic              d_stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write_en,
   output logic [7:0]        mem_data_in [0:3],
   input  logic [7:0]        mem_data_out [0:3],
   output logic              busy
);

   localparam int                CNT_W     = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(WORD_BYTES - 1);

   arb_state_t        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   gnt_t              gnt_reg, arb_gnt;
   logic              arb_gnt_d;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        wdata_reg [0:3];

   logic              grant, req_we, last_cycle, capture;
   logic [ADDR_W-1:0] req_addr;

   logic              if_valid_reg, if_valid_next;
   logic              d_valid_reg, d_valid_next;
   logic              mem_write_en_reg, mem_write_en_next;
   logic              busy_reg, busy_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [7:0]        mem_data_in_reg [0:3];
   logic [7:0]        mem_data_in_next [0:3];
   logic [31:0]       if_rdata_reg;
   logic [7:0]        d_rdata_reg [0:3];

   arb2_rr u_arb (
      .clk    (clk),
      .rst_b  (rst_b),
      .req_if (if_req),
      .req_d  (d_req),
      .en     (grant),
      .gnt_d  (arb_gnt_d)
   );

   assign arb_gnt    = arb_gnt_d ? GNT_D : GNT_IF;
   assign grant      = (state_reg == ARB_IDLE) && !halted && (if_req || d_req);
   assign req_addr   = ((arb_gnt == GNT_D) ? d_addr : if_addr) & WORD_MASK;
   assign req_we     = (arb_gnt == GNT_D) && d_we;
   assign last_cycle = (state_reg == ARB_ACCESS) && (cnt_reg == '0);
   assign capture    = last_cycle && !we_reg;

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_reg <= ARB_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ARB_IDLE: begin
            if (grant) begin
               state_next = ARB_ACCESS;
               cnt_next   = CNT_LOAD;
            end
         end
         ARB_ACCESS: begin
            if (cnt_reg == '0) begin
               state_next = ARB_RESP;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ARB_RESP: state_next = ARB_IDLE;
         default:  state_next = ARB_IDLE;
      endcase
   end

   // Registered outputs are computed from the upcoming state so they line up
   // with the state they describe.
   always_comb begin
      busy_next         = (state_next != ARB_IDLE);
      if_valid_next     = (state_next == ARB_RESP) && (gnt_reg == GNT_IF);
      d_valid_next      = (state_next == ARB_RESP) && (gnt_reg == GNT_D);
      mem_write_en_next = grant && req_we;
      mem_addr_next     = '0;
      if (grant) begin
         mem_addr_next = req_addr;
      end else if (state_next == ARB_ACCESS) begin
         mem_addr_next = addr_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         cnt_reg          <= '0;
         gnt_reg          <= GNT_IF;
         we_reg           <= 1'b0;
         addr_reg         <= '0;
         if_valid_reg     <= 1'b0;
         d_valid_reg      <= 1'b0;
         mem_write_en_reg <= 1'b0;
         busy_reg         <= 1'b0;
         mem_addr_reg     <= '0;
         if_rdata_reg     <= '0;
      end else begin
         cnt_reg          <= cnt_next;
         if_valid_reg     <= if_valid_next;
         d_valid_reg      <= d_valid_next;
         mem_write_en_reg <= mem_write_en_next;
         busy_reg         <= busy_next;
         mem_addr_reg     <= mem_addr_next;
         if (grant) begin
            gnt_reg  <= arb_gnt;
            we_reg   <= req_we;
            addr_reg <= req_addr;
         end
         if (capture && (gnt_reg == GNT_IF)) begin
            if_rdata_reg <= pack_lanes(mem_data_out);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
         assign mem_data_in_next[gi] = grant ? d_wdata[gi] :
                                       (state_next == ARB_ACCESS) ? wdata_reg[gi] : 8'h00;

         always_ff @(posedge clk) begin
            if (rst_b) begin
               wdata_reg[gi]       <= 8'h00;
               mem_data_in_reg[gi] <= 8'h00;
               d_rdata_reg[gi]     <= 8'h00;
            end else begin
               mem_data_in_reg[gi] <= mem_data_in_next[gi];
               if (grant) begin
                  wdata_reg[gi] <= d_wdata[gi];
               end
               if (capture && (gnt_reg == GNT_D)) begin
                  d_rdata_reg[gi] <= mem_data_out[gi];
               end
            end
         end

         assign mem_data_in[gi] = mem_data_in_reg[gi];
         assign d_rdata[gi]     = d_rdata_reg[gi];
      end
   endgenerate

   assign if_valid     = if_valid_reg;
   assign d_valid      = d_valid_reg;
   assign mem_write_en = mem_write_en_reg;
   assign busy         = busy_reg;
   assign mem_addr     = mem_addr_reg;
   assign if_rdata     = if_rdata_reg;
   assign if_stall     = if_req && !if_valid_reg;
   assign d_stall      = d_req && !d_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: latency-2 arbiter with a word memory model, plus a
// latency-1 instance for back-to-back fetch timing.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        halted;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [7:0]  d_wdata [0:3];
   logic        d_valid;
   logic [7:0]  d_rdata [0:3];
   logic        d_stall;
   logic [31:0] mem_addr;
   logic        mem_write_en;
   logic [7:0]  mem_data_in [0:3];
   logic [7:0]  mem_data_out [0:3];
   logic        busy;

   logic        l1_halted;
   logic        l1_if_req;
   logic [31:0] l1_if_addr;
   logic        l1_if_valid;
   logic [31:0] l1_if_rdata;
   logic        l1_if_stall;
   logic        l1_d_req;
   logic        l1_d_we;
   logic [31:0] l1_d_addr;
   logic [7:0]  l1_d_wdata [0:3];
   logic        l1_d_valid;
   logic [7:0]  l1_d_rdata [0:3];
   logic        l1_d_stall;
   logic [31:0] l1_mem_addr;
   logic        l1_mem_write_en;
   logic [7:0]  l1_mem_data_in [0:3];
   logic [7:0]  l1_mem_data_out [0:3];
   logic        l1_busy;

   int passed = 0;
   int total  = 0;
   int we_cnt = 0;

   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(32)) dut (
      .clk(clk), .rst_b(rst_b), .halted(halted),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
      .if_rdata(if_rdata), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
   );

   mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
      .clk(clk), .rst_b(rst_b), .halted(l1_halted),
      .if_req(l1_if_req), .if_addr(l1_if_addr), .if_valid(l1_if_valid),
      .if_rdata(l1_if_rdata), .if_stall(l1_if_stall),
      .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
      .d_valid(l1_d_valid), .d_rdata(l1_d_rdata), .d_stall(l1_d_stall),
      .mem_addr(l1_mem_addr), .mem_write_en(l1_mem_write_en),
      .mem_data_in(l1_mem_data_in), .mem_data_out(l1_mem_data_out), .busy(l1_busy)
   );

   // Word memory model: combinational read, write on the strobe edge.
   logic [31:0] rd_word;
   assign rd_word = mem[mem_addr[9:2]];
   assign mem_data_out[0] = rd_word[31:24];
   assign mem_data_out[1] = rd_word[23:16];
   assign mem_data_out[2] = rd_word[15:8];
   assign mem_data_out[3] = rd_word[7:0];

   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[mem_addr[9:2]] <= {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
         we_cnt <= we_cnt + 1;
      end
   end

   assign l1_mem_data_out[0] = l1_mem_addr[7:0];
   assign l1_mem_data_out[1] = 8'h5A;
   assign l1_mem_data_out[2] = 8'hC3;
   assign l1_mem_data_out[3] = 8'h01;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] d_rd();
      return {d_rdata[0], d_rdata[1], d_rdata[2], d_rdata[3]};
   endfunction

   function automatic logic [31:0] d_min();
      return {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
   endfunction

   initial begin
      int bad;
      int stall_cnt;
      int valid_cnt;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'h2008_0005;
      mem[8'h41] = 32'h1122_3344;

      rst_b = 1'b1; halted = 1'b0;
      if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0;
      for (int i = 0; i < 4; i++) begin
         d_wdata[i] = 8'h00; l1_d_wdata[i] = 8'h00;
      end
      l1_halted = 1'b0; l1_if_req = 1'b0; l1_if_addr = 32'h0;
      l1_d_req = 1'b0; l1_d_we = 1'b0; l1_d_addr = 32'h0;

      // Requests raised during reset must not be granted until release.
      if_req = 1'b1; if_addr = 32'h0000_0040;
      d_req = 1'b1; d_addr = 32'h0000_0104;
      tick; tick;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_d_valid", 32'(d_valid), 32'd0);
      chk("rst_we", 32'(mem_write_en), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_data_in", d_min(), 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rd(), 32'h0);
      rst_b = 1'b0;

      // Tie after reset: fetch, then data, then fetch again.
      tick;
      chk("tie1_mem_addr", mem_addr, 32'h0000_0040);
      chk("tie1_busy", 32'(busy), 32'd1);
      chk("tie1_d_stall", 32'(d_stall), 32'd1);
      tick;
      chk("tie1_addr_c2", mem_addr, 32'h0000_0040);
      chk("tie1_no_valid_c2", 32'(if_valid), 32'd0);
      tick;
      chk("fetch_valid", 32'(if_valid), 32'd1);
      chk("fetch_rdata", if_rdata, 32'h2008_0005);
      chk("fetch_if_stall", 32'(if_stall), 32'd0);
      chk("fetch_no_d_valid", 32'(d_valid), 32'd0);
      if_req = 1'b0;
      tick;
      chk("resp_end_valid", 32'(if_valid), 32'd0);
      chk("resp_end_busy", 32'(busy), 32'd0);
      chk("idle_mem_addr", mem_addr, 32'h0);
      if_req = 1'b1;
      tick;
      chk("tie2_gnt_d", mem_addr, 32'h0000_0104);
      tick; tick;
      chk("load_valid", 32'(d_valid), 32'd1);
      chk("load_rdata", d_rd(), 32'h1122_3344);
      d_req = 1'b0;
      tick;
      d_req = 1'b1;
      tick;
      chk("tie3_gnt_if", mem_addr, 32'h0000_0040);
      tick; tick;
      chk("tie3_if_valid", 32'(if_valid), 32'd1);
      if_req = 1'b0; d_req = 1'b0;
      tick;
      chk("no_write_yet", 32'(we_cnt), 32'd0);

      // Store then load at an unaligned address.
      d_we = 1'b1; d_addr = 32'h0000_0103;
      d_wdata[0] = 8'hDE; d_wdata[1] = 8'hAD; d_wdata[2] = 8'hBE; d_wdata[3] = 8'hEF;
      d_req = 1'b1;
      tick;
      chk("st_mem_addr", mem_addr, 32'h0000_0100);
      chk("st_we_c1", 32'(mem_write_en), 32'd1);
      chk("st_data_in", d_min(), 32'hDEAD_BEEF);
      tick;
      chk("st_we_c2", 32'(mem_write_en), 32'd0);
      chk("st_addr_c2", mem_addr, 32'h0000_0100);
      tick;
      chk("st_valid", 32'(d_valid), 32'd1);
      chk("st_rdata_kept", d_rd(), 32'h1122_3344);
      chk("st_one_strobe", 32'(we_cnt), 32'd1);
      d_req = 1'b0;
      tick;
      d_we = 1'b0; d_req = 1'b1;
      tick;
      chk("ld_mem_addr", mem_addr, 32'h0000_0100);
      chk("ld_no_we", 32'(mem_write_en), 32'd0);
      tick; tick;
      chk("ld_valid", 32'(d_valid), 32'd1);
      chk("ld_rdata", d_rd(), 32'hDEAD_BEEF);
      d_req = 1'b0;
      tick;
      chk("strobes_total", 32'(we_cnt), 32'd1);

      // Halted raised mid-access with a data request pending.
      if_req = 1'b1; if_addr = 32'h0000_0040;
      tick;
      d_req = 1'b1; d_addr = 32'h0000_0104; halted = 1'b1;
      tick; tick;
      chk("halt_inflight_valid", 32'(if_valid), 32'd1);
      if_req = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (busy || (mem_addr != 32'h0) || d_valid) bad++;
      end
      chk("halt_no_grant", 32'(bad), 32'd0);
      halted = 1'b0;
      tick;
      chk("unhalt_gnt_d", mem_addr, 32'h0000_0104);
      tick; tick;
      chk("unhalt_d_valid", 32'(d_valid), 32'd1);
      d_req = 1'b0;
      tick;

      // Reset asserted in the second ACCESS cycle of a load.
      d_req = 1'b1; d_addr = 32'h0000_0104;
      tick; tick;
      rst_b = 1'b1;
      tick;
      chk("mrst_d_valid", 32'(d_valid), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_mem_addr", mem_addr, 32'h0);
      chk("mrst_d_rdata", d_rd(), 32'h0);
      chk("mrst_if_rdata", if_rdata, 32'h0);
      rst_b = 1'b0;
      tick;
      chk("mrst_regrant_addr", mem_addr, 32'h0000_0104);
      chk("mrst_regrant_busy", 32'(busy), 32'd1);
      tick; tick;
      chk("mrst_reload_valid", 32'(d_valid), 32'd1);
      chk("mrst_reload_rdata", d_rd(), 32'h1122_3344);
      d_req = 1'b0;
      tick;

      // Latency 1: fetch held high gives a valid every third cycle.
      l1_if_req = 1'b1; l1_if_addr = 32'h0000_0010;
      stall_cnt = 0; valid_cnt = 0;
      for (int k = 0; k < 9; k++) begin
         tick;
         chk($sformatf("l1_valid_k%0d", k), 32'(l1_if_valid), (k % 3 == 1) ? 32'd1 : 32'd0);
         if (l1_if_stall) stall_cnt++;
         if (l1_if_valid) valid_cnt++;
         if (k == 1) chk("l1_rdata", l1_if_rdata, 32'h105A_C301);
      end
      l1_if_req = 1'b0;
      chk("l1_stall_cnt", 32'(stall_cnt), 32'd6);
      chk("l1_valid_cnt", 32'(valid_cnt), 32'd3);
      tick; tick;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
